// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared shifter state encoding, panel defaults and {R,G,B} channel slice indices
package led_matrix_pkg;
  localparam int PANEL_WIDTH_DEF = 64;
  localparam int ROW_ADDR_W_DEF = 5;
  localparam int COLOR_DEPTH_DEF = 7;
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;
  typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, CLK_LO, CLK_HI, DONE} state_t;
endpackage

// File: rtl/led_gamma_lut.sv
// led_gamma_lut: combinational gamma-2.2 table per channel (0->0, max->max), x^2.2 ~ 0.2x^3+0.8x^2
module led_gamma_lut
  import led_matrix_pkg::*;
#(
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF
) (
  input  logic [COLOR_DEPTH-1:0] din,
  output logic [COLOR_DEPTH-1:0] dout
);
  localparam longint MAXV = longint'(2**COLOR_DEPTH - 1);
  logic [COLOR_DEPTH-1:0] lut [2**COLOR_DEPTH];
  for (genvar g = 0; g < 2**COLOR_DEPTH; g++) begin : g_lut
    localparam longint X = longint'(g);
    localparam longint V = (X * X * X + 4 * X * X * MAXV) / (5 * MAXV * MAXV);
    assign lut[g] = COLOR_DEPTH'(V);
  end
  assign dout = lut[din];
endmodule

// File: rtl/led_line_shifter.sv
// led_line_shifter: shifts one framebuffer line into a HUB75 chain per request; LED_SHIFT_GAMMA_EN adds a gamma LUT before the PWM compare
module led_line_shifter
  import led_matrix_pkg::*;
#(
  parameter int PANEL_WIDTH = PANEL_WIDTH_DEF,
  parameter int ROW_ADDR_W  = ROW_ADDR_W_DEF,
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int COL_ADDR_W  = $clog2(PANEL_WIDTH)
) (
  input  logic                            clk_25MHz,
  input  logic                            rst_n,
  input  logic                            next_line_begin,
  input  logic [ROW_ADDR_W-1:0]           next_line_addr,
  input  logic [COLOR_DEPTH-1:0]          next_line_pwm,
  output logic                            next_line_done,
  output logic                            fb_rd_en,
  output logic [ROW_ADDR_W+COL_ADDR_W-1:0] fb_addr,
  input  logic [3*COLOR_DEPTH-1:0]        fb_data_top,
  input  logic [3*COLOR_DEPTH-1:0]        fb_data_bot,
  output logic [2:0]                      rgb_top,
  output logic [2:0]                      rgb_bot,
  output logic                            sclk
);
  localparam logic [COL_ADDR_W-1:0] LAST = COL_ADDR_W'(PANEL_WIDTH - 1);
  state_t state, next;
  logic [COL_ADDR_W-1:0] col;
  logic [ROW_ADDR_W-1:0] row;
  logic [COLOR_DEPTH-1:0] pwm;
  logic [COLOR_DEPTH-1:0] val_top [3];
  logic [COLOR_DEPTH-1:0] val_bot [3];
  logic [2:0] cmp_top, cmp_bot;
  logic load_rgb;
  for (genvar c = 0; c < 3; c++) begin : g_ch
`ifdef LED_SHIFT_GAMMA_EN
    led_gamma_lut #(.COLOR_DEPTH(COLOR_DEPTH)) u_lut_top (.din(fb_data_top[c*COLOR_DEPTH +: COLOR_DEPTH]), .dout(val_top[c]));
    led_gamma_lut #(.COLOR_DEPTH(COLOR_DEPTH)) u_lut_bot (.din(fb_data_bot[c*COLOR_DEPTH +: COLOR_DEPTH]), .dout(val_bot[c]));
`else
    assign val_top[c] = fb_data_top[c*COLOR_DEPTH +: COLOR_DEPTH];
    assign val_bot[c] = fb_data_bot[c*COLOR_DEPTH +: COLOR_DEPTH];
`endif
    assign cmp_top[c] = val_top[c] > pwm;
    assign cmp_bot[c] = val_bot[c] > pwm;
  end
  assign load_rgb = state == LOAD || (state == CLK_HI && col != LAST);
  // state register
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next state and framebuffer read address; the read for col+1 overlaps the low half of col
  always_comb begin
    next = state;
    fb_rd_en = 1'b0;
    fb_addr = {row, col};
    case (state)
      IDLE: next = next_line_begin ? PREFETCH : IDLE;
      PREFETCH: begin
        fb_rd_en = 1'b1;
        fb_addr = {row, {COL_ADDR_W{1'b0}}};
        next = LOAD;
      end
      LOAD: next = CLK_LO;
      CLK_LO: begin
        fb_rd_en = col != LAST;
        fb_addr = {row, col + 1'b1};
        next = CLK_HI;
      end
      CLK_HI: next = col == LAST ? DONE : CLK_LO;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // line parameters captured on an accepted request; column advances at the end of each high phase
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) begin
      row <= '0;
      pwm <= '0;
      col <= '0;
    end else if (state == IDLE && next_line_begin) begin
      row <= next_line_addr;
      pwm <= next_line_pwm;
      col <= '0;
    end else if (state == CLK_HI && col != LAST) col <= col + 1'b1;
  // registered panel outputs: sclk high in CLK_HI, rgb updated while sclk is low, cleared at done
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) begin
      sclk <= 1'b0;
      next_line_done <= 1'b0;
      rgb_top <= '0;
      rgb_bot <= '0;
    end else begin
      sclk <= next == CLK_HI;
      next_line_done <= next == DONE;
      rgb_top <= load_rgb ? cmp_top : next == DONE ? 3'b000 : rgb_top;
      rgb_bot <= load_rgb ? cmp_bot : next == DONE ? 3'b000 : rgb_bot;
    end
endmodule
